// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
//   Two-master, one-slave arbiter for the CPU memory bus. Master 0 is the CPU
//   bus port, master 1 is the loader/DMA/debug port, and both share one RAM
//   slave. Ownership is round-robin. A grant is held until the slave finishes
//   the transfer. A watchdog abandons any transfer that the slave stalls for
//   too long.
//
//   Handshake: a master request (mN_read or mN_write) is the "valid" and
//   !mN_waitrequest is the "ready". A transfer completes in the cycle where the
//   owning master's strobe is high and its waitrequest is low. Read data is
//   valid to the master in that same cycle. A master must hold address, data,
//   byteenable and strobes stable while it is stalled. The slave side uses the
//   same rule with s_read/s_write and s_waitrequest.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   m0_*                  master 0 bus: address/read/write/writedata/byteenable
//                         in, waitrequest/readdata out
//   m1_*                  master 1 bus, same set as m0_*
//   s_*                   slave bus: address/read/write/writedata/byteenable
//                         out, waitrequest/readdata in
//   grant                 one-hot owner (bit0 = master 0, bit1 = master 1). It
//                         is decoded from the FSM state only, so it doubles as
//                         the state debug view (00 = IDLE).
//   timeout_err           sticky watchdog flag, cleared only by reset
//
// Parameters
//   TIMEOUT_CYCLES        stalled cycles allowed for one transfer before it is
//                         abandoned (>= 2)
module mips_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;    // index of the master served last
  logic [CW-1:0] cnt_q, cnt_d;      // consecutive stalled cycles of this grant
  logic          terr_q, terr_d;

  logic          req0, req1;
  logic          owning, sel1;
  logic [31:0]   own_address, own_writedata;
  logic [3:0]    own_byteenable;
  logic          own_read, own_write, own_req;
  logic          fire;
  logic          own_wait;
  logic [31:0]   own_rdata;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  assign sel1   = (state_q == OWN1);
  assign owning = (state_q == OWN0) || (state_q == OWN1);

  // Only the owner's signals are muxed here. Outside OWN1 this selects
  // master 0, but the slave strobes are gated off in IDLE, so nothing leaks.
  assign own_address    = sel1 ? m1_address    : m0_address;
  assign own_writedata  = sel1 ? m1_writedata  : m0_writedata;
  assign own_byteenable = sel1 ? m1_byteenable : m0_byteenable;
  assign own_read       = sel1 ? m1_read       : m0_read;
  assign own_write      = sel1 ? m1_write      : m0_write;
  assign own_req        = own_read | own_write;

  // The watchdog depends only on the counter and the slave, never on master
  // inputs. This keeps the "no master-to-master combinational path" property.
  assign fire = owning && s_waitrequest && (cnt_q == CNT_LAST);

  // On a watchdog abort the master is released with zero data.
  assign own_wait  = s_waitrequest & ~fire;
  assign own_rdata = fire ? 32'h0 : s_readdata;

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    terr_d         = terr_q;
    s_address      = '0;
    s_writedata    = '0;
    s_byteenable   = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0 && req1) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end

      OWN0, OWN1: begin
        s_address    = own_address;
        s_writedata  = own_writedata;
        s_byteenable = own_byteenable;
        // Write wins when a master raises both strobes.
        s_write      = own_write & ~fire;
        s_read       = own_read & ~own_write & ~fire;

        if (sel1) begin
          m1_waitrequest = own_wait;
          m1_readdata    = own_rdata;
        end else begin
          m0_waitrequest = own_wait;
          m0_readdata    = own_rdata;
        end

        // The grant ends on any of three events: normal completion, the
        // master dropping its request (protocol violation, no error flag), or
        // a watchdog abort. All three return to IDLE, so the other master
        // gets its turn next.
        if (fire || !own_req || !s_waitrequest) begin
          state_d = IDLE;
          last_d  = sel1;
          cnt_d   = '0;
          terr_d  = terr_q | fire;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;   // master 0 wins the first tie
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  assign grant       = {state_q == OWN1, state_q == OWN0};
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter. The bench has three parts.
//   - A behavioural slave RAM (smem) with programmable waitstates.
//   - A reference memory (ref_mem). Each master issue pushes the read data it
//     expects onto that master's queue. Each master owns a disjoint half of
//     the RAM, so the expected value depends only on that master's own
//     history.
//   - A negedge monitor. It pops the queue and compares whenever a master is
//     released (granted and waitrequest low). It also checks the bus
//     invariants every cycle.
module tb_mips_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m0_address = '0, m1_address = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address, s_writedata;
  logic        s_read, s_write;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest = 1'b1;
  logic [31:0] s_readdata = '0;
  logic [1:0]  grant;
  logic        timeout_err;

  int total = 0;
  int bad = 0;
  logic [32:0] exp_q0[$];   // {is_read, expected readdata}
  logic [32:0] exp_q1[$];
  int order_q[$];
  bit rec_order = 1'b0;
  bit exp_to = 1'b0;
  logic [31:0] smem [64];
  logic [31:0] ref_mem [64];
  int wait_mode = 0;        // < 0: random 0..3 waitstates, else fixed count
  int slave_stalls = 0;
  int cur_target = 0;

  mips_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  // ---------------- clock / global bound ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation bound expired, bad=%0d", bad);
    $fatal(1);
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural slave ----------------
  always @(posedge clk) begin
    #2;
    if (grant != 2'b00) begin
      s_waitrequest = (slave_stalls < cur_target);
      s_readdata = s_waitrequest ? $urandom : smem[s_address[5:0]];
    end else begin
      s_waitrequest = 1'($urandom_range(0, 1));
      s_readdata = $urandom;
    end
  end

  always @(negedge clk) begin
    if (grant == 2'b00) begin
      slave_stalls = 0;
      cur_target = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
    end else if (s_waitrequest) begin
      slave_stalls++;
    end else begin
      if (s_write)
        for (int b = 0; b < 4; b++)
          if (s_byteenable[b]) smem[s_address[5:0]][8*b +: 8] = s_writedata[8*b +: 8];
      slave_stalls = 0;
    end
  end

  // ---------------- scoreboard monitor ----------------
  task automatic completion(input int n, input logic [31:0] rdata);
    logic [32:0] e;
    total++;
    if ((n == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
      bad++;
      $display("FAIL unexpected_completion m%0d: actual=release required=no release", n);
    end else begin
      e = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (e[32]) check($sformatf("m%0d_readdata", n), rdata, e[31:0]);
    end
    if (rec_order) order_q.push_back(n);
  endtask

  always @(negedge clk) begin
    check("grant_onehot0", 32'(grant != 2'b11), 32'd1);
    check("timeout_err", 32'(timeout_err), 32'(exp_to));
    check("rd_wr_exclusive", 32'(s_read & s_write), 32'd0);
    case (grant)
      2'b00: begin
        check("idle_s_strobes", 32'({s_read, s_write}), 32'd0);
        check("idle_waitrequests", 32'({m0_waitrequest, m1_waitrequest}), 32'd3);
      end
      2'b01: begin
        check("m1_blocked", 32'(m1_waitrequest), 32'd1);
        check("m1_readdata_zero", m1_readdata, 32'd0);
        check("s_address_m0", s_address, m0_address);
        if (!m0_waitrequest) completion(0, m0_readdata);
      end
      2'b10: begin
        check("m0_blocked", 32'(m0_waitrequest), 32'd1);
        check("m0_readdata_zero", m0_readdata, 32'd0);
        check("s_address_m1", s_address, m1_address);
        if (!m1_waitrequest) completion(1, m1_readdata);
      end
      default: ;
    endcase
  end

  // ---------------- reference model + drivers ----------------
  task automatic push_exp(input int n, input bit wr, input int idx, input logic [31:0] data,
                          input logic [3:0] be, input bit to);
    logic [31:0] rd;
    rd = to ? 32'h0 : ref_mem[idx];
    if (wr && !to)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
    if (n == 0) exp_q0.push_back({!wr, rd});
    else        exp_q1.push_back({!wr, rd});
  endtask

  task automatic drive_m(input int n, input bit rd, input bit wr, input int idx,
                         input logic [31:0] data, input logic [3:0] be);
    if (n == 0) begin
      m0_address = 32'hBFC0_0000 + 32'(idx);
      m0_read = rd; m0_write = wr; m0_writedata = data; m0_byteenable = be;
    end else begin
      m1_address = 32'(idx);
      m1_read = rd; m1_write = wr; m1_writedata = data; m1_byteenable = be;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_txn(input int n, input bit wr, input int idx, input logic [31:0] data,
                       input logic [3:0] be, input bit to);
    int cyc;
    logic w;
    push_exp(n, wr, idx, data, be, to);
    drive_m(n, !wr, wr, idx, data, be);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      w = (n == 0) ? m0_waitrequest : m1_waitrequest;
    end while (w && cyc < 200);
    total++;
    if (w) begin
      bad++;
      $display("FAIL m%0d_release_bound: actual=stalled required=released within 200 cycles", n);
    end
    tick();
    drive_m(n, 1'b0, 1'b0, idx, data, be);
  endtask

  task automatic rand_master(input int n, input int cnt, input bit gaps);
    for (int i = 0; i < cnt; i++) begin
      m_txn(n, 1'($urandom_range(0, 1)), n * 32 + int'($urandom_range(0, 31)),
            $urandom, 4'($urandom_range(0, 15)), 1'b0);
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_m(0, 1'b0, 1'b0, 0, 32'h0, 4'h0);
    drive_m(1, 1'b0, 1'b0, 32, 32'h0, 4'h0);
    tick();
    exp_to = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd33;
    int c;
    for (int i = 0; i < 64; i++) begin
      smem[i] = $urandom;
      ref_mem[i] = smem[i];
    end
    smem[0] = 32'h8C02_0000;
    ref_mem[0] = 32'h8C02_0000;

    // Reset state, then single master read with zero waitstates.
    wait_mode = 0;
    do_reset();
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_s_read", 32'(s_read), 32'd0);
    check("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
    check("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
    tick();
    push_exp(0, 1'b0, 0, 32'h0, 4'h0, 1'b0);
    drive_m(0, 1'b1, 1'b0, 0, 32'h0, 4'hF);
    @(negedge clk);
    check("single_c1_grant", 32'(grant), 32'd0);
    check("single_c1_s_read", 32'(s_read), 32'd0);
    @(negedge clk);
    check("single_c2_grant", 32'(grant), 32'd1);
    check("single_c2_s_read", 32'(s_read), 32'd1);
    check("single_c2_s_address", s_address, 32'hBFC0_0000);
    check("single_c2_wait", 32'(m0_waitrequest), 32'd0);
    check("single_c2_rdata", m0_readdata, 32'h8C02_0000);
    tick();
    drive_m(0, 1'b0, 1'b0, 0, 32'h0, 4'h0);
    @(negedge clk);
    check("single_c3_grant", 32'(grant), 32'd0);

    // Simultaneous requests from reset: m0 read, m1 write.
    do_reset();
    push_exp(0, 1'b0, 1, 32'h0, 4'h0, 1'b0);
    push_exp(1, 1'b1, 40, 32'h1234_5678, 4'hF, 1'b0);
    drive_m(0, 1'b1, 1'b0, 1, 32'h0, 4'hF);
    drive_m(1, 1'b0, 1'b1, 40, 32'h1234_5678, 4'hF);
    @(negedge clk);
    check("simul_c1_grant", 32'(grant), 32'd0);
    @(negedge clk);
    check("simul_c2_grant", 32'(grant), 32'd1);
    tick();
    drive_m(0, 1'b0, 1'b0, 1, 32'h0, 4'h0);
    @(negedge clk);
    check("simul_c3_grant", 32'(grant), 32'd0);
    @(negedge clk);
    check("simul_c4_grant", 32'(grant), 32'd2);
    check("simul_c4_s_write", 32'(s_write), 32'd1);
    check("simul_c4_s_writedata", s_writedata, 32'h1234_5678);
    check("simul_c4_s_byteenable", 32'(s_byteenable), 32'hF);
    tick();
    drive_m(1, 1'b0, 1'b0, 40, 32'h0, 4'h0);
    @(negedge clk);
    check("simul_c5_grant", 32'(grant), 32'd0);

    // Three waitstates on an m1 read, while m0 waits behind it.
    wait_mode = 3;
    tick();
    rd33 = ref_mem[33];
    push_exp(1, 1'b0, 33, 32'h0, 4'h0, 1'b0);
    drive_m(1, 1'b1, 1'b0, 33, 32'h0, 4'hF);
    @(negedge clk);
    check("ws_c1_grant", 32'(grant), 32'd0);
    tick();
    push_exp(0, 1'b0, 2, 32'h0, 4'h0, 1'b0);
    drive_m(0, 1'b1, 1'b0, 2, 32'h0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ws_stall_grant", 32'(grant), 32'd2);
      check("ws_stall_m1_wait", 32'(m1_waitrequest), 32'd1);
      check("ws_stall_m0_wait", 32'(m0_waitrequest), 32'd1);
    end
    @(negedge clk);
    check("ws_done_m1_wait", 32'(m1_waitrequest), 32'd0);
    check("ws_done_m1_rdata", m1_readdata, rd33);
    check("ws_done_m0_wait", 32'(m0_waitrequest), 32'd1);
    tick();
    drive_m(1, 1'b0, 1'b0, 33, 32'h0, 4'h0);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (m0_waitrequest && c < 20);
    check("ws_m0_served", 32'(m0_waitrequest), 32'd0);
    tick();
    drive_m(0, 1'b0, 1'b0, 2, 32'h0, 4'h0);

    // Fairness under saturation: 4 back-to-back transfers per master.
    wait_mode = -1;
    do_reset();
    rec_order = 1'b1;
    fork
      rand_master(0, 4, 1'b0);
      rand_master(1, 4, 1'b0);
    join
    rec_order = 1'b0;
    check("fair_count", 32'(order_q.size()), 32'd8);
    for (int i = 0; i < order_q.size(); i++)
      check($sformatf("fair_order_%0d", i), 32'(order_q[i]), 32'(i % 2));

    // Random mixed traffic.
    fork
      rand_master(0, 25, 1'b1);
      rand_master(1, 25, 1'b1);
    join

    // Watchdog: slave never releases.
    wait_mode = 99;
    tick();
    push_exp(0, 1'b0, 3, 32'h0, 4'h0, 1'b1);
    drive_m(0, 1'b1, 1'b0, 3, 32'h0, 4'hF);
    @(negedge clk);
    check("wd_c1_grant", 32'(grant), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wd_stall_grant", 32'(grant), 32'd1);
      check("wd_stall_wait", 32'(m0_waitrequest), 32'd1);
    end
    @(negedge clk);
    check("wd_fire_wait", 32'(m0_waitrequest), 32'd0);
    check("wd_fire_rdata", m0_readdata, 32'd0);
    check("wd_fire_s_read", 32'(s_read), 32'd0);
    check("wd_fire_err_not_yet", 32'(timeout_err), 32'd0);
    tick();
    exp_to = 1'b1;
    drive_m(0, 1'b0, 1'b0, 3, 32'h0, 4'h0);
    @(negedge clk);
    check("wd_after_grant", 32'(grant), 32'd0);
    check("wd_after_err", 32'(timeout_err), 32'd1);
    tick();
    // An abandoned write must not reach the RAM.
    m_txn(0, 1'b1, 4, $urandom, 4'hF, 1'b1);
    wait_mode = 0;
    m_txn(0, 1'b0, 4, 32'h0, 4'h0, 1'b0);

    // Protocol violation: m0 drops its read mid-stall.
    wait_mode = 99;
    drive_m(0, 1'b1, 1'b0, 5, 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check("pv_c2_grant", 32'(grant), 32'd1);
    check("pv_c2_s_read", 32'(s_read), 32'd1);
    tick();
    drive_m(0, 1'b0, 1'b0, 5, 32'h0, 4'h0);
    @(negedge clk);
    check("pv_c3_s_read", 32'(s_read), 32'd0);
    check("pv_c3_wait", 32'(m0_waitrequest), 32'd1);
    @(negedge clk);
    check("pv_c4_grant", 32'(grant), 32'd0);

    // Reset mid-transfer.
    drive_m(0, 1'b1, 1'b0, 6, 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check("rmt_c2_grant", 32'(grant), 32'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rmt_c3_grant", 32'(grant), 32'd1);
    tick();
    exp_to = 1'b0;
    @(negedge clk);
    check("rmt_c4_grant", 32'(grant), 32'd0);
    check("rmt_c4_s_read", 32'(s_read), 32'd0);
    check("rmt_c4_err", 32'(timeout_err), 32'd0);
    tick();
    reset = 1'b0;
    drive_m(0, 1'b0, 1'b0, 6, 32'h0, 4'h0);
    wait_mode = 0;
    tick();
    m_txn(0, 1'b0, 6, 32'h0, 4'h0, 1'b0);

    // Final state of the RAM and scoreboard.
    repeat (3) tick();
    for (int i = 0; i < 64; i++) check($sformatf("mem_%0d", i), smem[i], ref_mem[i]);
    check("exp_q0_empty", 32'(exp_q0.size()), 32'd0);
    check("exp_q1_empty", 32'(exp_q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
